// File: rtl/sync_arith_driver.sv
// -----------------------------------------------------------------------------
// sync_arith_driver
//
// Command-side initiator for the synchronous arithmetic unit. One request
// (A, B, op) is accepted over a valid/ready handshake and driven onto the
// unit's operand/opcode inputs. After LAT cycles the unit's result and status
// are captured and returned over a valid/ready response handshake. Saturating
// operation and error counters are kept for the status logic.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_A/B, i_req_op       request operands and opcode
//   o_arg_A/B, o_op           operands and opcode driven to the unit
//   i_result, i_status        result and status from the unit
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_result/status       captured result and status
//   o_busy                    high while waiting for or holding a response
//   i_clr_count               synchronous clear of both counters
//   o_op_count, o_err_count   saturating completed-op and error counters
// -----------------------------------------------------------------------------
module sync_arith_driver #(
    parameter int BITS  = 32,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [BITS-1:0]  i_req_A,
    input  logic [BITS-1:0]  i_req_B,
    input  logic [1:0]       i_req_op,
    output logic [BITS-1:0]  o_arg_A,
    output logic [BITS-1:0]  o_arg_B,
    output logic [1:0]       o_op,
    input  logic [BITS-1:0]  i_result,
    input  logic [3:0]       i_status,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [BITS-1:0]  o_rsp_result,
    output logic [3:0]       o_rsp_status,
    output logic             o_busy,
    input  logic             i_clr_count,
    output logic [CNT_W-1:0] o_op_count,
    output logic [CNT_W-1:0] o_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The wait counter reaches 0 on the edge before capture, so the capture
    // edge lands exactly LAT edges after the accept edge.
    localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t            state_q,      state_d;
    logic [3:0]        wait_cnt_q,   wait_cnt_d;
    logic [BITS-1:0]   arg_a_q,      arg_a_d;
    logic [BITS-1:0]   arg_b_q,      arg_b_d;
    logic [1:0]        op_q,         op_d;
    logic [BITS-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_status_q, rsp_status_d;
    logic [CNT_W-1:0]  op_count_q,   op_count_d;
    logic [CNT_W-1:0]  err_count_q,  err_count_d;
    logic              req_ready_q,  req_ready_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              busy_q,       busy_d;

    // Next-state, datapath and counter logic.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        arg_a_d      = arg_a_q;
        arg_b_d      = arg_b_q;
        op_d         = op_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        op_count_d   = op_count_q;
        err_count_d  = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    arg_a_d    = i_req_A;
                    arg_b_d    = i_req_B;
                    op_d       = i_req_op;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = ST_WAIT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    rsp_result_d = i_result;
                    rsp_status_d = i_status;
                    op_count_d   = sat_inc(op_count_q);
                    if (i_status[3]) begin
                        err_count_d = sat_inc(err_count_q);
                    end else begin
                        err_count_d = err_count_q;
                    end
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides any increment computed above.
        if (i_clr_count) begin
            op_count_d  = {CNT_W{1'b0}};
            err_count_d = {CNT_W{1'b0}};
        end else begin
            op_count_d  = op_count_d;
            err_count_d = err_count_d;
        end

        // Handshake flags are registered from the next state so they carry
        // no combinational path from i_req_valid or i_rsp_ready.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            arg_a_q      <= {BITS{1'b0}};
            arg_b_q      <= {BITS{1'b0}};
            op_q         <= 2'd0;
            rsp_result_q <= {BITS{1'b0}};
            rsp_status_q <= 4'd0;
            op_count_q   <= {CNT_W{1'b0}};
            err_count_q  <= {CNT_W{1'b0}};
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            arg_a_q      <= arg_a_d;
            arg_b_q      <= arg_b_d;
            op_q         <= op_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
            op_count_q   <= op_count_d;
            err_count_q  <= err_count_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_arg_A      = arg_a_q;
    assign o_arg_B      = arg_b_q;
    assign o_op         = op_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_status = rsp_status_q;
    assign o_busy       = busy_q;
    assign o_op_count   = op_count_q;
    assign o_err_count  = err_count_q;

endmodule

// File: tb/tb_sync_arith_driver.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for sync_arith_driver (LAT=2, CNT_W=2 so the
// counter saturation point is reachable in a handful of operations).
// -----------------------------------------------------------------------------
module tb_sync_arith_driver;

    localparam int BITS  = 32;
    localparam int LAT   = 2;
    localparam int CNT_W = 2;

    logic             i_clk;
    logic             i_reset;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [BITS-1:0]  i_req_A;
    logic [BITS-1:0]  i_req_B;
    logic [1:0]       i_req_op;
    logic [BITS-1:0]  o_arg_A;
    logic [BITS-1:0]  o_arg_B;
    logic [1:0]       o_op;
    logic [BITS-1:0]  i_result;
    logic [3:0]       i_status;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [BITS-1:0]  o_rsp_result;
    logic [3:0]       o_rsp_status;
    logic             o_busy;
    logic             i_clr_count;
    logic [CNT_W-1:0] o_op_count;
    logic [CNT_W-1:0] o_err_count;

    int errors = 0;
    int checks = 0;

    sync_arith_driver #(.BITS(BITS), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_A      (i_req_A),
        .i_req_B      (i_req_B),
        .i_req_op     (i_req_op),
        .o_arg_A      (o_arg_A),
        .o_arg_B      (o_arg_B),
        .o_op         (o_op),
        .i_result     (i_result),
        .i_status     (i_status),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_status (o_rsp_status),
        .o_busy       (o_busy),
        .i_clr_count  (i_clr_count),
        .o_op_count   (o_op_count),
        .o_err_count  (o_err_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Present a request, let it be accepted, and stop just before the capture edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] res, input logic [3:0] st);
        i_req_A     = a;
        i_req_B     = b;
        i_req_op    = op;
        i_result    = res;
        i_status    = st;
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    initial begin
        int exp_err;

        i_reset     = 1'b0;
        i_req_valid = 1'b0;
        i_req_A     = 32'd0;
        i_req_B     = 32'd0;
        i_req_op    = 2'd0;
        i_result    = 32'd0;
        i_status    = 4'd0;
        i_rsp_ready = 1'b0;
        i_clr_count = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_busy",      32'(o_busy),      32'd0);
        chk("rst_op_count",  32'(o_op_count),  32'd0);
        i_reset = 1'b1;
        tick();

        // Reset in the middle of WAIT abandons the operation
        i_req_A     = 32'h0000_0001;
        i_req_B     = 32'h0000_0002;
        i_req_op    = 2'd1;
        i_result    = 32'h1111_1111;
        i_status    = 4'b1000;
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        chk("midw_busy",      32'(o_busy),      32'd1);
        chk("midw_req_ready", 32'(o_req_ready), 32'd0);
        chk("midw_arg_A",     o_arg_A,          32'h0000_0001);
        i_reset = 1'b0;
        #2;
        chk("midw_rst_arg_A",     o_arg_A,              32'd0);
        chk("midw_rst_arg_B",     o_arg_B,              32'd0);
        chk("midw_rst_op",        32'(o_op),            32'd0);
        chk("midw_rst_req_ready", 32'(o_req_ready),     32'd1);
        chk("midw_rst_busy",      32'(o_busy),          32'd0);
        chk("midw_rst_result",    o_rsp_result,         32'd0);
        chk("midw_rst_status",    32'(o_rsp_status),    32'd0);
        tick();
        tick();
        chk("midw_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        i_reset = 1'b1;
        tick();
        tick();
        tick();
        chk("midw_after_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("midw_after_op_count",  32'(o_op_count),  32'd0);
        chk("midw_after_err_count", 32'(o_err_count), 32'd0);

        // Single op, capture LAT edges after accept
        i_req_A     = 32'h0000_00F0;
        i_req_B     = 32'h0000_0004;
        i_req_op    = 2'b11;
        i_result    = 32'h0000_0F00;
        i_status    = 4'b0100;
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        chk("single_arg_A",     o_arg_A,          32'h0000_00F0);
        chk("single_arg_B",     o_arg_B,          32'h0000_0004);
        chk("single_op",        32'(o_op),        32'd3);
        chk("single_valid_e1",  32'(o_rsp_valid), 32'd0);
        tick();
        chk("single_valid_e2",  32'(o_rsp_valid), 32'd0);
        tick();
        chk("single_valid_cap", 32'(o_rsp_valid),  32'd1);
        chk("single_result",    o_rsp_result,      32'h0000_0F00);
        chk("single_status",    32'(o_rsp_status), 32'b0100);
        chk("single_op_count",  32'(o_op_count),   32'd1);
        chk("single_err_count", 32'(o_err_count),  32'd0);

        // Backpressure: response held while the unit's result changes
        i_result    = 32'hDEAD_BEEF;
        i_status    = 4'b1111;
        i_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid",     32'(o_rsp_valid), 32'd1);
            chk("bp_result",    o_rsp_result,     32'h0000_0F00);
            chk("bp_req_ready", 32'(o_req_ready), 32'd0);
            chk("bp_arg_A",     o_arg_A,          32'h0000_00F0);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        tick();
        chk("bp_accept_valid", 32'(o_rsp_valid), 32'd0);
        chk("bp_accept_ready", 32'(o_req_ready), 32'd1);
        chk("bp_op_count",     32'(o_op_count),  32'd1);

        // Error status increments the error counter
        issue(32'hFFFF_FFFB, 32'h0000_0003, 2'b00, 32'h1234_5678, 4'b1000);
        tick();
        chk("err_status",    32'(o_rsp_status), 32'b1000);
        chk("err_result",    o_rsp_result,      32'h1234_5678);
        chk("err_err_count", 32'(o_err_count),  32'd1);
        chk("err_op_count",  32'(o_op_count),   32'd2);
        tick();
        chk("err_done_valid", 32'(o_rsp_valid), 32'd0);

        // Saturation at all-ones for a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            issue(32'(k), 32'd1, 2'b01, 32'hA5A5_0000, 4'b1001);
            tick();
            exp_err = (2 + k > 3) ? 3 : 2 + k;
            chk("sat_op_count",  32'(o_op_count),  32'd3);
            chk("sat_err_count", 32'(o_err_count), 32'(exp_err));
            tick();
        end

        // Clear on the capture edge wins over the increment
        issue(32'd7, 32'd8, 2'b10, 32'h0000_0077, 4'b1000);
        i_clr_count = 1'b1;
        tick();
        i_clr_count = 1'b0;
        chk("clr_rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("clr_op_count",  32'(o_op_count),  32'd0);
        chk("clr_err_count", 32'(o_err_count), 32'd0);
        tick();

        // Streaming with request valid held high and consumer always ready
        i_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_req_A  = 32'h100 + 32'(k);
            i_req_B  = 32'h200 + 32'(k);
            i_req_op = 2'(k);
            i_result = 32'h0000_00A0 + 32'(k);
            i_status = 4'(k);
            tick();
            chk("str_accept_op",    32'(o_op),        32'(k));
            chk("str_accept_A",     o_arg_A,          32'h100 + 32'(k));
            chk("str_accept_ready", 32'(o_req_ready), 32'd0);
            tick();
            chk("str_wait_valid",   32'(o_rsp_valid), 32'd0);
            chk("str_wait_ready",   32'(o_req_ready), 32'd0);
            tick();
            chk("str_cap_valid",    32'(o_rsp_valid),  32'd1);
            chk("str_cap_result",   o_rsp_result,      32'h0000_00A0 + 32'(k));
            chk("str_cap_status",   32'(o_rsp_status), 32'(k));
            chk("str_cap_op_count", 32'(o_op_count),   32'(k + 1 > 3 ? 3 : k + 1));
            tick();
            chk("str_hs_valid",     32'(o_rsp_valid), 32'd0);
            chk("str_hs_ready",     32'(o_req_ready), 32'd1);
            chk("str_hs_op_held",   32'(o_op),        32'(k));
        end
        i_req_valid = 1'b0;
        tick();
        chk("str_end_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_arith_driver.md
Name: sync_arith_driver

Overview:
- Command-side initiator for the synchronous arithmetic unit.
- Accepts one operation request (A, B, op) over a valid/ready handshake and drives the unit's operand and opcode inputs.
- Waits a fixed number of cycles, then captures the unit's result and 4-bit status.
- Returns them over a valid/ready response handshake and keeps saturating operation and error counters for the status logic.

Parameters:
- BITS, 32, operand/result width; must match the arithmetic unit.
- LAT, 2, cycles from operand drive to result capture; legal range 1..15.
- CNT_W, 16, width of o_op_count and o_err_count.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  driver can accept a request.
- i_req_A  in  BITS  operand A (signed).
- i_req_B  in  BITS  operand B (signed).
- i_req_op  in  2  opcode: 00 convert, 01 compare, 10 set, 11 shift.
- o_arg_A  out  BITS  operand A to the arithmetic unit.
- o_arg_B  out  BITS  operand B to the arithmetic unit.
- o_op  out  2  opcode to the arithmetic unit.
- i_result  in  BITS  result from the arithmetic unit.
- i_status  in  4  status from the unit: [3] ERROR, [2] odd zero count, [1] all zeros, [0] overflow.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer accepts the response.
- o_rsp_result  out  BITS  captured result.
- o_rsp_status  out  4  captured status.
- o_busy  out  1  high in WAIT or RESP.
- i_clr_count  in  1  synchronous clear of both counters.
- o_op_count  out  CNT_W  completed operations, saturating.
- o_err_count  out  CNT_W  completed operations with status[3]=1, saturating.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE.
  - o_arg_A, o_arg_B, o_op, o_rsp_result, o_rsp_status and both counters go to 0.
  - o_rsp_valid=0, o_busy=0, o_req_ready=1.
- Reset mid-operation abandons the operation: no response is produced and no counter changes.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On an edge with i_req_valid=1, register i_req_A/B/op into o_arg_A/B/op, load wait counter with LAT-1, go to WAIT.
- WAIT:
  - o_req_ready=0.
  - Counter decrements once per edge.
  - On the edge where the counter is 0, capture i_result into o_rsp_result and i_status into o_rsp_status, update counters, go to RESP.
- Timing: a request accepted at edge t0 is captured at edge t0+LAT; o_rsp_valid rises after that edge.
- RESP:
  - o_rsp_valid=1; o_rsp_result and o_rsp_status are held stable until accepted.
  - On an edge with i_rsp_ready=1, go to IDLE; o_rsp_valid drops after that edge.
  - New requests are not accepted in RESP, so the earliest next accept is the edge after the response handshake.
- Back-to-back throughput: one operation per LAT+2 cycles with the response consumer always ready.
- o_arg_A/B/op keep their last value outside IDLE→WAIT transitions; they never glitch to 0 between operations.
- Counters:
  - o_op_count increments by 1 at capture.
  - o_err_count increments by 1 at capture when i_status[3]=1.
  - Both saturate at all-ones and do not wrap.
  - i_clr_count=1 zeroes both counters on that edge and wins over a simultaneous increment.
- Inputs that arrive outside their accepting state (i_req_valid outside IDLE, i_rsp_ready outside RESP) are ignored.
- No combinational path from i_req_valid to o_req_ready, or from i_rsp_ready to o_rsp_valid.

Test Plan:
- Reset: assert i_reset=0 mid-WAIT → all outputs 0, o_req_ready=1, no o_rsp_valid pulse, counters 0.
- Single op (LAT=2): A=32'h0000_00F0, B=4, op=11, i_result=32'h0000_0F00, i_status=4'b0100 at capture.
  - Expected: o_rsp_valid 2 edges after accept, o_rsp_result=32'h0000_0F00, o_rsp_status=4'b0100, o_op_count=1, o_err_count=0.
- Backpressure: hold i_rsp_ready=0 for 5 cycles while i_result changes to 32'hDEAD_BEEF.
  - Expected: o_rsp_result stays at the captured value, o_req_ready=0 throughout, accept on the 6th edge.
- Error status: i_status=4'b1000 at capture → o_err_count increments to 1; o_rsp_status=4'b1000.
- Saturation/clear (CNT_W=2): 5 ops with status[3]=1 → both counters stick at 3.
  - Then i_clr_count=1 on the same edge as a capture → both counters read 0 afterwards.
- Streaming: 4 requests with i_req_valid held high and i_rsp_ready=1.
  - Expected: accepts exactly every LAT+2=4 cycles and 4 responses in order with matching opcodes.
